// File: rtl/zjh_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zjh_scan_pkg
// Purpose  : Shared constants and FSM state type for the digit scanner.
// Revision : 1.0 - initial release
// ============================================================================
package zjh_scan_pkg;

  localparam int NUM_DIGITS   = 4;
  localparam int DEF_TICK_DIV = 1000;
  localparam int DEF_SCAN_DIV = 50;

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/zjh_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : zjh_bcd_digit
// Purpose  : One BCD decade (0..9) with a combinational carry out for chaining.
// Revision : 1.0 - initial release
// ============================================================================
module zjh_bcd_digit
  import zjh_scan_pkg::*;
(
  input  logic       Clock,
  input  logic       Aclr,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] val,
  output logic       carry
);

  logic [3:0] r_val;

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      r_val <= 4'd0;
    end else if (clr) begin
      r_val <= 4'd0;
    end else if (inc) begin
      r_val <= (r_val == 4'd9) ? 4'd0 : r_val + 4'd1;
    end
  end

  // Carry is asserted in the same cycle as the 9 -> 0 roll so the next
  // decade advances on the same edge.
  assign carry = inc & (r_val == 4'd9);
  assign val   = r_val;

endmodule
`default_nettype wire

// File: rtl/zjh_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : zjh_digit_scanner
// Purpose  : Run/stop 4-digit BCD counter with multiplexed digit scan output.
// Revision : 1.0 - initial release
// ============================================================================
module zjh_digit_scanner
  import zjh_scan_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic       Clock,
  input  logic       Aclr,
  input  logic       key_run,
  input  logic       key_clr,
  output logic [1:0] sel,
  output logic [3:0] digit,
  output logic [3:0] dig_en_n,
  output logic       running,
  output logic       wrap
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] c_TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] c_SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [2:0]    r_run_sync;
  logic [1:0]    r_clr_sync;
  logic          w_run_rise;
  logic          w_clr;
  scan_state_t   r_state;
  scan_state_t   w_state_nxt;
  logic          w_start;
  logic          w_running;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [NUM_DIGITS:0] w_carry;
  logic [3:0]    w_val [NUM_DIGITS];
  logic          r_wrap;
  logic [SW-1:0] r_scan_cnt;
  logic          w_scan_step;
  logic [1:0]    r_sel;
  logic [1:0]    w_sel_nxt;
  logic [3:0]    r_dig_en_n;

  // Bit 2 of the run chain is the previous synchronised level for edge detect.
  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      r_run_sync <= 3'b000;
      r_clr_sync <= 2'b00;
    end else begin
      r_run_sync <= {r_run_sync[1:0], key_run};
      r_clr_sync <= {r_clr_sync[0], key_clr};
    end
  end

  assign w_run_rise = r_run_sync[1] & ~r_run_sync[2];
  assign w_clr      = r_clr_sync[1];

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      r_state <= ST_STOPPED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    if (w_clr) begin
      w_state_nxt = ST_STOPPED;
    end else if (w_run_rise) begin
      case (r_state)
        ST_STOPPED: begin
          w_state_nxt = ST_RUNNING;
          w_start     = 1'b1;
        end
        default: w_state_nxt = ST_STOPPED;
      endcase
    end
  end

  assign w_running = (r_state == ST_RUNNING);
  assign w_tick    = w_running & ~w_clr & (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      r_tick_cnt <= '0;
    end else if (w_clr || w_start) begin
      r_tick_cnt <= '0;
    end else if (w_running) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  assign w_carry[0] = w_tick;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    zjh_bcd_digit u_digit (
      .Clock (Clock),
      .Aclr  (Aclr),
      .inc   (w_carry[gi]),
      .clr   (w_clr),
      .val   (w_val[gi]),
      .carry (w_carry[gi+1])
    );
  end

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_carry[NUM_DIGITS];
    end
  end

  assign w_scan_step = (r_scan_cnt == c_SCAN_LAST);
  assign w_sel_nxt   = r_sel + 2'd1;

  // Scan keeps running in every state so a stopped display stays lit.
  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      r_scan_cnt <= '0;
      r_sel      <= 2'd0;
      r_dig_en_n <= 4'b1110;
    end else begin
      r_scan_cnt <= w_scan_step ? '0 : r_scan_cnt + 1'b1;
      if (w_scan_step) begin
        r_sel      <= w_sel_nxt;
        r_dig_en_n <= ~(4'b0001 << w_sel_nxt);
      end
    end
  end

  assign sel      = r_sel;
  assign digit    = w_val[r_sel];
  assign dig_en_n = r_dig_en_n;
  assign running  = w_running;
  assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_zjh_digit_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_zjh_digit_scanner
// Purpose  : Randomised self-checking bench against an integer count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zjh_digit_scanner;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int GUARD    = 60000;

  logic       r_clk     = 1'b0;
  logic       r_aclr    = 1'b0;
  logic       r_key_run = 1'b0;
  logic       r_key_clr = 1'b0;
  logic [1:0] w_sel;
  logic [3:0] w_digit;
  logic [3:0] w_dig_en_n;
  logic       w_running;
  logic       w_wrap;

  int n_checks    = 0;
  int n_errors    = 0;
  int n_wrap_seen = 0;

  int m_cnt;
  int m_pre;
  int m_scan;
  bit m_run;
  bit m_wrap;
  bit runq[$];
  bit clrq[$];

  always #5 r_clk = ~r_clk;

  zjh_digit_scanner #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .Clock    (r_clk),
    .Aclr     (r_aclr),
    .key_run  (r_key_run),
    .key_clr  (r_key_clr),
    .sel      (w_sel),
    .digit    (w_digit),
    .dig_en_n (w_dig_en_n),
    .running  (w_running),
    .wrap     (w_wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_pre  = 0;
    m_scan = 0;
    m_run  = 1'b0;
    m_wrap = 1'b0;
    runq.delete();
    clrq.delete();
    repeat (4) begin
      runq.push_back(1'b0);
      clrq.push_back(1'b0);
    end
  endtask

  // Keys act two edges after being sampled; a run press is a 0->1 change
  // between consecutive samples.
  task automatic model_edge();
    bit clr_e;
    bit rise;
    bit tick;
    runq.push_back(r_key_run);
    clrq.push_back(r_key_clr);
    if (runq.size() > 8) void'(runq.pop_front());
    if (clrq.size() > 8) void'(clrq.pop_front());
    clr_e  = clrq[$-2];
    rise   = runq[$-2] && !runq[$-3];
    tick   = m_run && (m_pre == TICK_DIV - 1) && !clr_e;
    m_wrap = tick && (m_cnt == 9999);
    if (clr_e) m_cnt = 0;
    else if (tick) m_cnt = (m_cnt + 1) % 10000;
    if (clr_e) begin
      m_pre = 0;
      m_run = 1'b0;
    end else begin
      if (m_run) m_pre = (m_pre + 1) % TICK_DIV;
      if (rise) begin
        if (!m_run) m_pre = 0;
        m_run = !m_run;
      end
    end
    m_scan++;
  endtask

  task automatic step();
    int sel;
    int p;
    logic [3:0] en;
    @(posedge r_clk);
    model_edge();
    #1;
    sel = (m_scan / SCAN_DIV) % 4;
    p = 1;
    repeat (sel) p = p * 10;
    en = ~(4'b0001 << sel);
    if (w_wrap) n_wrap_seen++;
    check("sel", 32'(w_sel), sel);
    check("dig_en_n", 32'(w_dig_en_n), 32'(en));
    check("digit", 32'(w_digit), (m_cnt / p) % 10);
    check("running", 32'(w_running), 32'(m_run));
    check("wrap", 32'(w_wrap), 32'(m_wrap));
  endtask

  task automatic press_run();
    r_key_run = 1'b1;
    step();
    r_key_run = 1'b0;
  endtask

  // Only meaningful while stopped: walks one full scan to assemble the count.
  task automatic read_count(output int v);
    int d [4];
    for (int i = 0; i < 4; i++) d[i] = -1;
    repeat (SCAN_DIV * 4) begin
      step();
      d[w_sel] = int'(w_digit);
    end
    v = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
  endtask

  task automatic run_until(input int target);
    int g = 0;
    while (!(m_run && m_cnt == target && m_pre == 0) && g < GUARD) begin
      step();
      g++;
    end
    if (g >= GUARD) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout waiting for count %0d: got %0d", target, m_cnt);
    end
  endtask

  initial begin
    int lat;
    int v;
    int hold_run;
    int hold_clr;

    model_reset();
    repeat (3) @(posedge r_clk);
    #1;
    check("rst_sel", 32'(w_sel), 0);
    check("rst_digit", 32'(w_digit), 0);
    check("rst_dig_en_n", 32'(w_dig_en_n), 32'hE);
    check("rst_running", 32'(w_running), 0);
    check("rst_wrap", 32'(w_wrap), 0);
    r_aclr = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      check("scan_seq", 32'(w_sel), ((i + 1) / SCAN_DIV) % 4);
    end

    // Start: latency, then stop landing exactly on the 40th running cycle.
    r_key_run = 1'b1;
    step();
    r_key_run = 1'b0;
    lat = 1;
    while (!w_running && lat < 10) begin
      step();
      lat++;
    end
    check("run_latency", lat, 3);
    repeat (37) step();
    press_run();
    repeat (2) step();
    check("stopped_at_40", 32'(w_running), 0);
    read_count(v);
    check("count_after_40", v, 10);

    // Wrap: stop so it takes effect on the 9999 -> 0000 tick.
    press_run();
    n_wrap_seen = 0;
    run_until(9999);
    step();
    press_run();
    step();
    step();
    repeat (6) step();
    read_count(v);
    check("wrap_count_zero", v, 0);
    check("wrap_pulses", n_wrap_seen, 1);

    // Stop at 0123 and hold.
    press_run();
    run_until(123);
    press_run();
    repeat (100) step();
    check("held_stopped", 32'(w_running), 0);
    read_count(v);
    check("held_count", v, 123);

    // Clear, then clear with a simultaneous run press.
    r_key_clr = 1'b1;
    repeat (4) step();
    r_key_clr = 1'b0;
    repeat (3) step();
    read_count(v);
    check("clr_count", v, 0);
    check("clr_running", 32'(w_running), 0);
    r_key_clr = 1'b1;
    r_key_run = 1'b1;
    repeat (5) step();
    r_key_clr = 1'b0;
    repeat (4) step();
    r_key_run = 1'b0;
    repeat (4) step();
    check("clr_wins", 32'(w_running), 0);

    // Random key activity.
    hold_run = 0;
    hold_clr = 0;
    repeat (1500) begin
      if (hold_run > 0) begin
        hold_run--;
        if (hold_run == 0) r_key_run = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        r_key_run = 1'b1;
        hold_run  = int'($urandom_range(1, 3));
      end
      if (hold_clr > 0) begin
        hold_clr--;
        if (hold_clr == 0) r_key_clr = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        r_key_clr = 1'b1;
        hold_clr  = int'($urandom_range(1, 3));
      end
      step();
    end
    r_key_run = 1'b0;
    r_key_clr = 1'b0;
    repeat (4) step();

    // Mid-run asynchronous reset at 0057.
    r_key_clr = 1'b1;
    repeat (3) step();
    r_key_clr = 1'b0;
    repeat (3) step();
    press_run();
    run_until(57);
    #1;
    r_aclr = 1'b0;
    #1;
    check("mrst_sel", 32'(w_sel), 0);
    check("mrst_digit", 32'(w_digit), 0);
    check("mrst_dig_en_n", 32'(w_dig_en_n), 32'hE);
    check("mrst_running", 32'(w_running), 0);
    check("mrst_wrap", 32'(w_wrap), 0);
    repeat (2) @(posedge r_clk);
    #1;
    r_aclr = 1'b1;
    model_reset();
    repeat (6) step();
    check("mrst_after_running", 32'(w_running), 0);
    read_count(v);
    check("mrst_after_count", v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
